// File: rtl/cell_exerciser_pkg.sv
// Shared types, constants and helpers for the standard-cell exerciser.
// Truth tables are indexed by the input code {D,C,B,A}, with A as bit 0.
package cell_exerciser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int MAX_INPUTS = 4;

    localparam logic [15:0] TT_INV   = 16'h0001;
    localparam logic [15:0] TT_BUF   = 16'h0002;
    localparam logic [15:0] TT_AND2  = 16'h0008;
    localparam logic [15:0] TT_OR2   = 16'h000E;
    localparam logic [15:0] TT_NAND2 = 16'h0007;
    localparam logic [15:0] TT_XOR2  = 16'h0006;
    localparam logic [15:0] TT_XNOR2 = 16'h0009;
    localparam logic [15:0] TT_NAND3 = 16'h007F;
    localparam logic [15:0] TT_AOI21 = 16'h0007;
    localparam logic [15:0] TT_AOI22 = 16'h0777;

    // Out-of-range input counts are pulled into 1..MAX_INPUTS.
    function automatic logic [2:0] clamp_n(input logic [2:0] n);
        if (n == 3'd0)
            return 3'd1;
        else if (n > 3'(MAX_INPUTS))
            return 3'(MAX_INPUTS);
        else
            return n;
    endfunction

    // Ones in the N low bit positions; this is also the last vector code 2^N-1.
    function automatic logic [3:0] pin_mask(input logic [2:0] n);
        return 4'((5'd1 << n) - 5'd1);
    endfunction

endpackage

// File: rtl/cell_exerciser_sync2.sv
// Two-flop synchroniser bringing the asynchronous cell output into the clock domain.
module cell_exerciser_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cell_exerciser.sv
// Exhaustive stimulus generator and response checker for one combinational cell.
// Sweeps every input code, waits for the cell to settle, and records error statistics.
module cell_exerciser
    import cell_exerciser_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [2:0]  n_inputs_i,
    input  logic [15:0] truth_i,
    output logic [3:0]  stim_o,
    input  logic        resp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [4:0]  err_count_o,
    output logic        fail_valid_o,
    output logic [3:0]  first_fail_o
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  n_q, n_d;
    logic [15:0] truth_q, truth_d;
    logic [3:0]  v_q, v_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  stim_q, stim_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  err_q, err_d;
    logic        fv_q, fv_d;
    logic [3:0]  ff_q, ff_d;
    logic        resp_sync;

    cell_exerciser_sync2 u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (resp_i),
        .q   (resp_sync)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        truth_d = truth_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    n_d     = clamp_n(n_inputs_i);
                    truth_d = truth_i;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    v_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                stim_d  = v_q & pin_mask(n_q);
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST)
                    state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (resp_sync != truth_q[v_q]) begin
                    err_d = err_q + 5'd1;
                    if (!fv_q) begin
                        ff_d = v_q;
                        fv_d = 1'b1;
                    end
                end
                // Registered done/pass must be valid in the DONE cycle itself.
                if (v_q == pin_mask(n_q)) begin
                    done_d  = 1'b1;
                    pass_d  = (err_d == 5'd0);
                    state_d = ST_DONE;
                end else begin
                    v_d     = v_q + 4'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            n_q     <= 3'd1;
            truth_q <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            truth_q <= truth_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
        end
    end

    assign stim_o       = stim_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_count_o  = err_q;
    assign fail_valid_o = fv_q;
    assign first_fail_o = ff_q;

endmodule

// File: tb/tb_cell_exerciser.sv
// Directed bench for cell_exerciser: behavioural cell models drive resp_i and
// a scoreboard of expected sweep results is checked when done_o fires.
module tb_cell_exerciser;

    localparam int S = 4;

    localparam int M_AND2  = 0;
    localparam int M_STUCK = 1;
    localparam int M_AOI22 = 2;
    localparam int M_INV   = 3;

    typedef struct {
        int         lat;
        logic [4:0] err;
        logic       fv;
        logic [3:0] ff;
        logic       pass;
    } exp_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  n_inputs_i = 3'd0;
    logic [15:0] truth_i = 16'h0;
    logic [3:0]  stim_o;
    logic        resp_i;
    logic        busy_o, done_o, pass_o, fail_valid_o;
    logic [4:0]  err_count_o;
    logic [3:0]  first_fail_o;

    int   tests = 0;
    int   fails = 0;
    int   mode = M_AND2;
    exp_t sb[$];

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic cell_model(input int m, input logic [3:0] s);
        case (m)
            M_AND2:  return s[0] & s[1];
            M_AOI22: return ~((s[0] & s[1]) | (s[2] & s[3]));
            M_INV:   return ~s[0];
            default: return 1'b0;
        endcase
    endfunction

    assign resp_i = cell_model(mode, stim_o);

    cell_exerciser #(.SETTLE_CYCLES(S)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .start_i      (start_i),
        .n_inputs_i   (n_inputs_i),
        .truth_i      (truth_i),
        .stim_o       (stim_o),
        .resp_i       (resp_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_o       (pass_o),
        .err_count_o  (err_count_o),
        .fail_valid_o (fail_valid_o),
        .first_fail_o (first_fail_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".stim"}, 32'(stim_o), 32'd0);
        check({tag, ".busy"}, 32'(busy_o), 32'd0);
        check({tag, ".done"}, 32'(done_o), 32'd0);
        check({tag, ".pass"}, 32'(pass_o), 32'd0);
        check({tag, ".err"},  32'(err_count_o), 32'd0);
        check({tag, ".fv"},   32'(fail_valid_o), 32'd0);
        check({tag, ".ff"},   32'(first_fail_o), 32'd0);
    endtask

    // One full sweep; glitch_at > 0 pulses start_i once at that cycle after accept.
    task automatic run_sweep(input string tag, input int m, input logic [2:0] nin,
                             input logic [15:0] tt, input int glitch_at);
        exp_t e, got;
        int nc, nv, lat, stim_bad, done_cnt;
        logic y;
        mode = m;
        n_inputs_i = nin;
        truth_i = tt;
        nc = (nin == 3'd0) ? 1 : ((nin > 3'd4) ? 4 : int'(nin));
        nv = 1 << nc;
        e.lat = nv * (S + 2);
        e.err = '0; e.fv = 1'b0; e.ff = '0;
        for (int v = 0; v < nv; v++) begin
            y = cell_model(m, 4'(v));
            if (y !== tt[v]) begin
                e.err++;
                if (!e.fv) begin e.fv = 1'b1; e.ff = 4'(v); end
            end
        end
        e.pass = (e.err == 0);
        sb.push_back(e);

        @(negedge wb_clk_i);
        start_i = 1'b1;
        @(posedge wb_clk_i);
        #1 start_i = 1'b0;
        lat = 0; stim_bad = 0; done_cnt = 0;
        for (int c = 1; c <= e.lat + 10 && lat == 0; c++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            start_i = (c == glitch_at);
            if (stim_o !== 4'((c - 1) / (S + 2))) stim_bad++;
            if (done_o === 1'b1) lat = c;
        end
        start_i = 1'b0;
        got = sb.pop_front();
        check({tag, ".latency"}, 32'(lat), 32'(got.lat));
        check({tag, ".busy_in_done"}, 32'(busy_o), 32'd1);
        check({tag, ".stim_seq_bad"}, 32'(stim_bad), 32'd0);
        check({tag, ".err"}, 32'(err_count_o), 32'(got.err));
        check({tag, ".fv"}, 32'(fail_valid_o), 32'(got.fv));
        check({tag, ".ff"}, 32'(first_fail_o), 32'(got.ff));
        check({tag, ".pass"}, 32'(pass_o), 32'(got.pass));
        // done must be a single pulse and busy falls leaving DONE
        for (int c = 0; c < 3 * (S + 2); c++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (done_o === 1'b1) done_cnt++;
            if (c == 0) check({tag, ".busy_after"}, 32'(busy_o), 32'd0);
        end
        check({tag, ".extra_done"}, 32'(done_cnt), 32'd0);
        check({tag, ".pass_hold"}, 32'(pass_o), 32'(got.pass));
    endtask

    initial begin
        int done_cnt;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        check_reset_outputs("reset");

        run_sweep("and2",   M_AND2,  3'd2, 16'h0008, 0);
        run_sweep("or2_s0", M_STUCK, 3'd2, 16'h000E, 0);
        run_sweep("aoi22",  M_AOI22, 3'd4, 16'h0777, 0);
        run_sweep("inv_n0", M_INV,   3'd0, 16'h0001, 0);
        run_sweep("inv_n7", M_INV,   3'd7, 16'h0001, 0);
        run_sweep("glitch", M_AND2,  3'd2, 16'h0008, (S + 2) + 2);

        // Abort a sweep once one mismatch has been recorded.
        mode = M_STUCK;
        n_inputs_i = 3'd2;
        truth_i = 16'h000E;
        @(negedge wb_clk_i);
        start_i = 1'b1;
        @(posedge wb_clk_i);
        #1 start_i = 1'b0;
        repeat (2 * (S + 2) + 2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("abort.err_pre", 32'(err_count_o), 32'd1);
        check("abort.fv_pre", 32'(fail_valid_o), 32'd1);
        check("abort.ff_pre", 32'(first_fail_o), 32'd1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        check_reset_outputs("abort");
        done_cnt = 0;
        for (int c = 0; c < 5 * (S + 2); c++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (done_o === 1'b1 || busy_o === 1'b1) done_cnt++;
        end
        check("abort.no_done", 32'(done_cnt), 32'd0);

        run_sweep("fresh", M_AND2, 3'd2, 16'h0008, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cell_exerciser.md
# cell_exerciser

Self-timed stimulus generator and response checker for a single combinational standard cell on the LibreSilicon test wafer. It drives exhaustive input vectors onto the cell's input pins, samples the cell's Y pin through a synchroniser and compares each sample against a loaded truth table. It reports pass/fail, error count and the first failing vector. It sits between the user-project control logic (Wishbone/logic-analyzer registers) and one blackbox cell instance, and acts as the driving end of the cell's pin interface.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles held in SETTLE per vector; legal range 2..255.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  start request; level sampled in IDLE only.
- n_inputs_i  in  3  number of cell inputs; 0 is treated as 1, 5..7 are treated as 4.
- truth_i  in  16  expected Y per input code v, where v = {D,C,B,A} and A is bit 0.
- stim_o  out  4  registered drive to cell pins {D,C,B,A}.
- resp_i  in  1  cell Y pin; asynchronous.
- busy_o  out  1  high from DRIVE of vector 0 through DONE.
- done_o  out  1  one-cycle pulse in DONE.
- pass_o  out  1  error count equals 0; valid from DONE until the next start.
- err_count_o  out  5  mismatching vectors, 0..16.
- fail_valid_o  out  1  at least one mismatch recorded.
- first_fail_o  out  4  code of the first mismatching vector.

## Operation
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE with start_i=1:
  - capture the clamped n_inputs_i as N and capture truth_i.
  - clear err_count_o, fail_valid_o and first_fail_o; pass_o goes to 0.
  - vector index v=0; go to DRIVE.
- DRIVE (1 cycle): stim_o <= v zero-extended; bits at positions ≥ N are forced to 0. Go to SETTLE with the counter at 0.
- SETTLE: the counter increments each cycle. After SETTLE_CYCLES cycles go to SAMPLE.
- SAMPLE (1 cycle):
  - compare the synchronised response with truth[v].
  - on mismatch, err_count_o+1; if fail_valid_o was 0, set first_fail_o=v and fail_valid_o=1.
  - if v = 2^N−1 go to DONE, else v+1 and go to DRIVE.
- DONE (1 cycle): done_o=1 and pass_o=(err_count==0). Go to IDLE.
- stim_o holds its last value in IDLE. Results hold until the next accepted start.
- start_i is ignored outside IDLE; no queuing.
- Only truth bits 0..2^N−1 are used.
- err_count_o cannot exceed 16, so no saturation logic is needed.

## Timing
- Reset values: state IDLE, stim_o=0, busy_o=0, done_o=0, pass_o=0, err_count_o=0, fail_valid_o=0, first_fail_o=0, synchroniser flops=0.
- Reset mid-operation aborts the sweep. All outputs take reset values on the next edge and no done_o is produced.
- Per vector: 1 DRIVE + SETTLE_CYCLES + 1 SAMPLE cycles.
- done_o asserts 2^N·(SETTLE_CYCLES+2) cycles after the start-accept edge.
- resp_i passes through a 2-flop synchroniser. With SETTLE_CYCLES≥2, the value compared in SAMPLE reflects a stim_o held stable for at least SETTLE_CYCLES−1 cycles.
- busy_o falls on the edge leaving DONE. A start_i held high re-arms IDLE on the following cycle.

## Structure
- Package cell_exerciser_pkg holds:
  - state enum and MAX_INPUTS=4.
  - truth constants: INV 16'h0001, BUF 16'h0002, AND2 16'h0008, OR2 16'h000E, NAND2 16'h0007, XOR2 16'h0006, XNOR2 16'h0009, NAND3 16'h007F, AOI21 16'h0007, AOI22 16'h0777.
- Sub-module: sync2 (2-flop synchroniser for resp_i, reset to 0).
- Target size is about 150–250 lines RTL.

## Test plan
- AND2 model (Y=A&B), N=2, truth 16'h0008, SETTLE_CYCLES=4 -> done_o at cycle 24 after the start edge; pass_o=1, err_count_o=0, fail_valid_o=0; stim_o steps 0,1,2,3.
- OR2 with resp_i stuck at 0, N=2, truth 16'h000E -> err_count_o=3, first_fail_o=1, fail_valid_o=1, pass_o=0.
- AOI22 model, N=4, truth 16'h0777 -> 16 vectors; done_o at cycle 96; pass_o=1.
- INV model with n_inputs_i=0 (clamped to 1) and truth 16'h0001 -> 2 vectors; stim_o[3:1] always 0; pass_o=1. Also n_inputs_i=7 -> 16 vectors.
- start_i pulsed again during SETTLE of vector 1 -> ignored; a single done_o and correct counts.
- wb_rst_i asserted mid-sweep after one mismatch -> next cycle all outputs are at reset values and no done_o; a fresh start completes normally.
